keypad_scan_param: RTL and testbench
====================================

KEYPAD_SCAN_PARAM -- requirements
Module: keypad_scan_param

Interface
REQ-001 Parameters SHALL be: ROWS, default 4, number of row inputs.
REQ-002 COLS, default 4, number of column drive outputs.
REQ-003 SCAN_DIV, default 50000, clock cycles per column dwell; minimum 4.
REQ-004 DEB_FRAMES, default 20, consecutive identical scan frames required to accept a press or a release; minimum 1.
REQ-005 REPEAT_EN, default 0, 1 enables auto-repeat events.
REQ-006 REPEAT_DELAY, default 500, held frames before the first repeat event.
REQ-007 REPEAT_RATE, default 100, held frames between subsequent repeat events.
REQ-008 Derived KW = clog2(ROWS*COLS), width of the key code.
REQ-009 Ports: clk  in  1  system clock.
REQ-010 rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-011 row  in  ROWS  keypad rows, active low, asynchronous to clk.
REQ-012 col  out  COLS  column drive, exactly one bit low at all times.
REQ-013 evt_valid  out  1  event available.
REQ-014 evt_ready  in  1  consumer accepts the event while evt_valid=1.
REQ-015 evt_code  out  KW  key code = row_index*COLS + col_index.
REQ-016 evt_type  out  2  00 press, 01 repeat, 10 release.
REQ-017 key_down  out  1  high while an accepted key is held.
REQ-018 overflow  out  1  sticky; an event was dropped.
REQ-019 ovf_clr  in  1  synchronous clear of overflow.

Function
REQ-020 row SHALL pass through a 2-flop synchroniser before use.
REQ-021 Scan: col[i] low for SCAN_DIV cycles, then col[i+1]; COLS-1 wraps to 0; one pass over all columns is a frame.
REQ-022 Synchronised row SHALL be sampled in the last cycle of each dwell; a low bit r marks key r*COLS+col_index pressed.
REQ-023 At frame end the frame is classified NONE (0 keys), SINGLE(k) (exactly 1 key), or MULTI (2 or more).
REQ-024 FSM states: IDLE, DEB, HELD, REL; a counter cnt counts frames.
REQ-025 IDLE: SINGLE(k) -> DEB, cand=k, cnt=1; NONE or MULTI -> stay in IDLE.
REQ-026 DEB: SINGLE(cand) -> cnt+1, and when cnt reaches DEB_FRAMES -> HELD and emit press(cand); SINGLE(j), j!=cand -> restart with cand=j, cnt=1; NONE or MULTI -> IDLE.
REQ-027 With DEB_FRAMES=1 a single SINGLE frame SHALL go straight from IDLE to HELD and emit press.
REQ-028 HELD: any frame with cand pressed (SINGLE(cand) or MULTI including cand) -> stay and advance the repeat counter; a frame with cand not pressed -> REL, cnt=1.
REQ-029 REPEAT_EN=1: emit repeat(cand) at the REPEAT_DELAY-th held frame after press, then every REPEAT_RATE frames; the repeat counter clears on entry to HELD from DEB or REL.
REQ-030 REL: cand not pressed -> cnt+1, and when cnt reaches DEB_FRAMES -> IDLE and emit release(cand); cand pressed -> HELD.
REQ-031 key_down = 1 in HELD and REL, otherwise 0.
REQ-032 Events SHALL appear on evt_* the cycle after the frame-end sample edge.
REQ-033 evt_valid holds, with evt_code and evt_type stable, until evt_valid & evt_ready; it drops the next cycle unless a new event loads.
REQ-034 Output buffer is one entry; a new event while evt_valid=1 and evt_ready=0 SHALL be dropped and set overflow.
REQ-035 New event in the same cycle as the accepting handshake: the new event SHALL load, with no drop and no overflow.
REQ-036 ovf_clr clears overflow; if a drop happens in the same cycle, overflow stays set.

Reset
REQ-037 While rst_n=0: col has only col[0] low, dwell counter 0, FSM IDLE, cnt 0, evt_valid 0, evt_code 0, evt_type 00, key_down 0, overflow 0, synchroniser flops all 1.
REQ-038 Reset asserted mid-scan or mid-event SHALL abandon any pending event, with no release emitted.

Verification (SCAN_DIV=4, COLS=ROWS=4, DEB_FRAMES=3, evt_ready=1 unless stated)
REQ-039 Bench row model drives row[r]=col[c] for the pressed key (r,c), otherwise 1; key 1 held for 10 frames -> one press, code 1, evt_type 00, at the end of frame 3; key_down=1.
REQ-040 Release key 1 -> release, code 1, evt_type 10, after 3 NONE frames; key_down=0; no other events.
REQ-041 Key 9 bouncing with a pattern of 2 frames on, 1 frame off, repeated -> no event.
REQ-042 REPEAT_EN=1, REPEAT_DELAY=5, REPEAT_RATE=2, key 12 held 12 frames -> press, then repeats at held frames 5, 7, 9, 11.
REQ-043 evt_ready=0, key 2 press then release -> first event held stable, release dropped, overflow=1; ovf_clr pulse -> overflow=0.
REQ-044 Keys 1 and 2 pressed together from IDLE -> no event; rst_n pulse mid-HELD -> all outputs at reset values within one cycle.

Source files
------------

// File: rtl/keypad_scan_param.sv
// Matrix keypad scanner: drives one column low at a time and samples the rows.
// Each full scan is classified as no key, one key or several keys.
// A four-state debouncer turns stable frames into press, repeat and release events.
// Events are delivered through a one-entry valid/ready buffer with a sticky overflow flag.
`timescale 1ns/1ps

module keypad_scan_param #(
  parameter int unsigned ROWS         = 4,
  parameter int unsigned COLS         = 4,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned DEB_FRAMES   = 20,
  parameter int unsigned REPEAT_EN    = 0,
  parameter int unsigned REPEAT_DELAY = 500,
  parameter int unsigned REPEAT_RATE  = 100,
  localparam int unsigned KW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [ROWS-1:0] row,
  output logic [COLS-1:0] col,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [KW-1:0]   evt_code,
  output logic [1:0]      evt_type,
  output logic            key_down,
  output logic            overflow,
  input  logic            ovf_clr
);

  localparam int unsigned RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned DW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNTW = $clog2(DEB_FRAMES + 1);
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RPW  = (RMAX > 0) ? $clog2(RMAX + 1) : 1;

  localparam logic [1:0] EVT_PRESS   = 2'b00;
  localparam logic [1:0] EVT_REPEAT  = 2'b01;
  localparam logic [1:0] EVT_RELEASE = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DEB  = 2'd1,
    S_HELD = 2'd2,
    S_REL  = 2'd3
  } state_e;

  // synchroniser
  logic [ROWS-1:0] row_s1_q;
  logic [ROWS-1:0] row_s2_q;

  // scan timing
  logic [DW-1:0]   div_q;
  logic [CW-1:0]   col_idx_q;
  logic [CW-1:0]   col_idx_d;
  logic [COLS-1:0] col_q;
  logic            dwell_end_c;
  logic            frame_end_c;

  // per-column sample and running frame accumulation
  logic [1:0]      col_n_c;
  logic [RW-1:0]   col_row_c;
  logic [1:0]      acc_n_q;
  logic [RW-1:0]   acc_row_q;
  logic [CW-1:0]   acc_col_q;
  logic            acc_hit_q;
  logic [2:0]      sum_c;
  logic [1:0]      tot_c;
  logic [RW-1:0]   fr_row_c;
  logic [CW-1:0]   fr_col_c;
  logic            cand_here_c;
  logic            hit_c;
  logic            single_c;
  logic            same_c;

  // debouncer
  state_e          state_q;
  logic [CNTW-1:0] cnt_q;
  logic [CNTW-1:0] cnt_inc_c;
  logic            deb_last_c;
  logic [RW-1:0]   cand_row_q;
  logic [CW-1:0]   cand_col_q;
  logic [RPW-1:0]  rpt_q;
  logic [RPW-1:0]  rpt_nxt_c;
  logic            rpt_phase_q;
  logic            rpt_hit_c;
  logic            key_down_q;

  // event generation and output buffer
  logic            press_c;
  logic            repeat_c;
  logic            release_c;
  logic            ev_fire_c;
  logic            ev_drop_c;
  logic [1:0]      ev_type_c;
  logic [RW-1:0]   ev_row_c;
  logic [CW-1:0]   ev_col_c;
  logic [KW-1:0]   ev_code_c;
  logic            evt_valid_q;
  logic [KW-1:0]   evt_code_q;
  logic [1:0]      evt_type_q;
  logic            overflow_q;

  // Two-flop synchroniser for the asynchronous row inputs; idle rows read high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1_q <= '1;
      row_s2_q <= '1;
    end else begin
      row_s1_q <= row;
      row_s2_q <= row_s1_q;
    end
  end

  assign dwell_end_c = (div_q == DW'(SCAN_DIV - 1));
  assign frame_end_c = dwell_end_c && (col_idx_q == CW'(COLS - 1));
  assign col_idx_d   = (col_idx_q == CW'(COLS - 1)) ? '0 : col_idx_q + CW'(1);

  // Dwell counter and one-hot-low column driver.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= '0;
      col_idx_q <= '0;
      col_q     <= ~COLS'(1);
    end else if (dwell_end_c) begin
      div_q     <= '0;
      col_idx_q <= col_idx_d;
      col_q     <= ~(COLS'(1) << col_idx_d);
    end else begin
      div_q     <= div_q + DW'(1);
    end
  end

  // Count low rows in the current column (saturating at 2) and note the first one.
  always_comb begin
    col_n_c   = 2'd0;
    col_row_c = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (!row_s2_q[r]) begin
        if (col_n_c == 2'd0) col_row_c = RW'(r);
        if (col_n_c != 2'd2) col_n_c = col_n_c + 2'd1;
      end
    end
  end

  // Merge this column with the frame so far; the result classifies the frame at its last sample.
  always_comb begin
    sum_c       = {1'b0, acc_n_q} + {1'b0, col_n_c};
    tot_c       = (sum_c >= 3'd2) ? 2'd2 : sum_c[1:0];
    fr_row_c    = (acc_n_q == 2'd0) ? col_row_c : acc_row_q;
    fr_col_c    = (acc_n_q == 2'd0) ? col_idx_q : acc_col_q;
    cand_here_c = (col_idx_q == cand_col_q) && !row_s2_q[cand_row_q];
    hit_c       = acc_hit_q || cand_here_c;
    single_c    = (tot_c == 2'd1);
    same_c      = single_c && (fr_row_c == cand_row_q) && (fr_col_c == cand_col_q);
  end

  // Frame accumulator: updated at every dwell-end sample, cleared when the frame closes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_n_q   <= 2'd0;
      acc_row_q <= '0;
      acc_col_q <= '0;
      acc_hit_q <= 1'b0;
    end else if (dwell_end_c) begin
      if (frame_end_c) begin
        acc_n_q   <= 2'd0;
        acc_row_q <= '0;
        acc_col_q <= '0;
        acc_hit_q <= 1'b0;
      end else begin
        acc_n_q   <= tot_c;
        acc_row_q <= fr_row_c;
        acc_col_q <= fr_col_c;
        acc_hit_q <= hit_c;
      end
    end
  end

  assign cnt_inc_c  = cnt_q + CNTW'(1);
  assign deb_last_c = (cnt_inc_c == CNTW'(DEB_FRAMES));
  assign rpt_nxt_c  = rpt_q + RPW'(1);
  assign rpt_hit_c  = rpt_phase_q ? (rpt_nxt_c == RPW'(REPEAT_RATE))
                                  : (rpt_nxt_c == RPW'(REPEAT_DELAY));

  // Frame-end event decisions; a single debounce frame bypasses DEB and REL.
  assign press_c   = frame_end_c && single_c &&
                     (((state_q == S_IDLE) && (DEB_FRAMES == 1)) ||
                      ((state_q == S_DEB) && same_c && deb_last_c));
  assign release_c = frame_end_c && !hit_c &&
                     (((state_q == S_HELD) && (DEB_FRAMES == 1)) ||
                      ((state_q == S_REL) && deb_last_c));
  assign repeat_c  = (REPEAT_EN != 0) && frame_end_c && (state_q == S_HELD) &&
                     hit_c && rpt_hit_c;

  assign ev_fire_c = press_c || repeat_c || release_c;
  assign ev_drop_c = ev_fire_c && evt_valid_q && !evt_ready;
  assign ev_type_c = press_c ? EVT_PRESS : (repeat_c ? EVT_REPEAT : EVT_RELEASE);
  assign ev_row_c  = press_c ? fr_row_c : cand_row_q;
  assign ev_col_c  = press_c ? fr_col_c : cand_col_q;
  assign ev_code_c = KW'(ev_row_c) * KW'(COLS) + KW'(ev_col_c);

  // Debounce FSM, advanced once per frame; key_down tracks HELD/REL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cand_row_q  <= '0;
      cand_col_q  <= '0;
      rpt_q       <= '0;
      rpt_phase_q <= 1'b0;
      key_down_q  <= 1'b0;
    end else if (frame_end_c) begin
      unique case (state_q)
        S_IDLE: begin
          if (single_c) begin
            cand_row_q <= fr_row_c;
            cand_col_q <= fr_col_c;
            if (press_c) begin
              state_q     <= S_HELD;
              cnt_q       <= '0;
              rpt_q       <= '0;
              rpt_phase_q <= 1'b0;
              key_down_q  <= 1'b1;
            end else begin
              state_q <= S_DEB;
              cnt_q   <= CNTW'(1);
            end
          end
        end
        S_DEB: begin
          if (!single_c) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else if (!same_c) begin
            cand_row_q <= fr_row_c;
            cand_col_q <= fr_col_c;
            cnt_q      <= CNTW'(1);
          end else if (press_c) begin
            state_q     <= S_HELD;
            cnt_q       <= '0;
            rpt_q       <= '0;
            rpt_phase_q <= 1'b0;
            key_down_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_inc_c;
          end
        end
        S_HELD: begin
          if (hit_c) begin
            if (rpt_hit_c) begin
              rpt_q       <= '0;
              rpt_phase_q <= 1'b1;
            end else begin
              rpt_q <= rpt_nxt_c;
            end
          end else if (release_c) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            key_down_q <= 1'b0;
          end else begin
            state_q <= S_REL;
            cnt_q   <= CNTW'(1);
          end
        end
        S_REL: begin
          if (hit_c) begin
            state_q     <= S_HELD;
            cnt_q       <= '0;
            rpt_q       <= '0;
            rpt_phase_q <= 1'b0;
          end else if (release_c) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            key_down_q <= 1'b0;
          end else begin
            cnt_q <= cnt_inc_c;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          cnt_q      <= '0;
          key_down_q <= 1'b0;
        end
      endcase
    end
  end

  // One-entry event buffer; a load is allowed when empty or being drained this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid_q <= 1'b0;
      evt_code_q  <= '0;
      evt_type_q  <= 2'b00;
      overflow_q  <= 1'b0;
    end else begin
      if (ev_fire_c && (!evt_valid_q || evt_ready)) begin
        evt_valid_q <= 1'b1;
        evt_code_q  <= ev_code_c;
        evt_type_q  <= ev_type_c;
      end else if (evt_valid_q && evt_ready) begin
        evt_valid_q <= 1'b0;
      end
      if (ev_drop_c) begin
        overflow_q <= 1'b1;
      end else if (ovf_clr) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign col       = col_q;
  assign evt_valid = evt_valid_q;
  assign evt_code  = evt_code_q;
  assign evt_type  = evt_type_q;
  assign key_down  = key_down_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_keypad_scan_param.sv
// Bench for keypad_scan_param: three instances (plain, auto-repeat, single-frame debounce)
// driven by a matrix row model, with an ordered scoreboard of expected events.
`timescale 1ns/1ps

module tb_keypad_scan_param;

  localparam int FRAME = 16;  // SCAN_DIV * COLS cycles

  localparam int T_PRESS   = 0;
  localparam int T_REPEAT  = 1;
  localparam int T_RELEASE = 2;

  typedef struct {
    int inst;
    int code;
    int typ;
    int frame;   // frame whose end produces the event; -1 = timing not checked
  } exp_t;

  logic clk;
  logic rst_n;
  logic ovf_clr;
  logic rdy_a, rdy_b, rdy_c;
  logic [15:0] mask_a, mask_b, mask_c;
  logic [3:0] row_a, row_b, row_c;
  logic [3:0] col_a, col_b, col_c;
  logic v_a, v_b, v_c;
  logic [3:0] code_a, code_b, code_c;
  logic [1:0] type_a, type_b, type_c;
  logic kd_a, kd_b, kd_c;
  logic ovf_a, ovf_b, ovf_c;

  logic [2:0] v_w;
  logic [2:0] rdy_w;
  logic [3:0] code_w [3];
  logic [1:0] type_w [3];

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp;
  int   n_mis;
  int   fr;
  int   cyc;

  keypad_scan_param #(
    .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEB_FRAMES(3),
    .REPEAT_EN(0), .REPEAT_DELAY(5), .REPEAT_RATE(2)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .row(row_a), .col(col_a),
    .evt_valid(v_a), .evt_ready(rdy_a), .evt_code(code_a), .evt_type(type_a),
    .key_down(kd_a), .overflow(ovf_a), .ovf_clr(ovf_clr)
  );

  keypad_scan_param #(
    .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEB_FRAMES(3),
    .REPEAT_EN(1), .REPEAT_DELAY(5), .REPEAT_RATE(2)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .row(row_b), .col(col_b),
    .evt_valid(v_b), .evt_ready(rdy_b), .evt_code(code_b), .evt_type(type_b),
    .key_down(kd_b), .overflow(ovf_b), .ovf_clr(ovf_clr)
  );

  keypad_scan_param #(
    .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEB_FRAMES(1),
    .REPEAT_EN(0), .REPEAT_DELAY(5), .REPEAT_RATE(2)
  ) dut_c (
    .clk(clk), .rst_n(rst_n), .row(row_c), .col(col_c),
    .evt_valid(v_c), .evt_ready(rdy_c), .evt_code(code_c), .evt_type(type_c),
    .key_down(kd_c), .overflow(ovf_c), .ovf_clr(ovf_clr)
  );

  assign v_w       = {v_c, v_b, v_a};
  assign rdy_w     = {rdy_c, rdy_b, rdy_a};
  assign code_w[0] = code_a;
  assign code_w[1] = code_b;
  assign code_w[2] = code_c;
  assign type_w[0] = type_a;
  assign type_w[1] = type_b;
  assign type_w[2] = type_c;

  // Pressed key (r,c) connects row r to column c; rows idle high.
  function automatic logic [3:0] row_model(input logic [15:0] m, input logic [3:0] c);
    logic [3:0] r_v;
    r_v = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int cc = 0; cc < 4; cc++)
        if (m[r*4+cc] && !c[cc]) r_v[r] = 1'b0;
    return r_v;
  endfunction

  always_comb row_a = row_model(mask_a, col_a);
  always_comb row_b = row_model(mask_b, col_b);
  always_comb row_c = row_model(mask_c, col_c);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycles since reset release, independent of the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push(input int inst, input int code, input int typ, input int frame);
    exp_t e;
    e.inst  = inst;
    e.code  = code;
    e.typ   = typ;
    e.frame = frame;
    sb_q.push_back(e);
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) begin
      repeat (FRAME) @(negedge clk);
      fr++;
    end
  endtask

  // Every accepted event is checked against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        if (v_w[i] && rdy_w[i]) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_evt_inst", 32'(i), 32'hFFFF_FFFF);
          end else begin
            mon_e = sb_q.pop_front();
            chk("evt_inst", 32'(i), 32'(mon_e.inst));
            chk("evt_code", 32'(code_w[i]), 32'(mon_e.code));
            chk("evt_type", 32'(type_w[i]), 32'(mon_e.typ));
            if (mon_e.frame >= 0) chk("evt_cycle", 32'(cyc), 32'(FRAME * mon_e.frame));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    n_cmp = 0; n_mis = 0; fr = 0;
    rst_n = 1'b0; ovf_clr = 1'b0;
    rdy_a = 1'b1; rdy_b = 1'b1; rdy_c = 1'b1;
    mask_a = '0; mask_b = '0; mask_c = '0;
    repeat (3) @(negedge clk);
    chk("rst_col",      32'(col_a),  32'hE);
    chk("rst_valid",    32'(v_a),    32'd0);
    chk("rst_code",     32'(code_a), 32'd0);
    chk("rst_type",     32'(type_a), 32'd0);
    chk("rst_key_down", 32'(kd_a),   32'd0);
    chk("rst_overflow", 32'(ovf_a),  32'd0);
    rst_n = 1'b1;

    // key 1 held 10 frames then released
    base = fr;
    push(0, 1, T_PRESS, base + 3);
    mask_a = 16'h0002;
    frames(5);
    chk("k1_key_down_held", 32'(kd_a), 32'd1);
    frames(5);
    push(0, 1, T_RELEASE, base + 13);
    mask_a = '0;
    frames(2);
    chk("k1_key_down_rel", 32'(kd_a), 32'd1);
    frames(3);
    chk("k1_key_down_idle", 32'(kd_a), 32'd0);
    chk("k1_sb_empty", 32'(sb_q.size()), 32'd0);

    // key 9 bouncing 2 on / 1 off
    for (int k = 0; k < 4; k++) begin
      mask_a = 16'h0200;
      frames(2);
      mask_a = '0;
      frames(1);
    end
    chk("bounce_key_down", 32'(kd_a), 32'd0);
    chk("bounce_sb_empty", 32'(sb_q.size()), 32'd0);

    // keys 1 and 2 together from idle
    mask_a = 16'h0006;
    frames(5);
    chk("multi_key_down", 32'(kd_a), 32'd0);
    mask_a = '0;
    frames(2);
    chk("multi_sb_empty", 32'(sb_q.size()), 32'd0);

    // auto-repeat: key 12 held for 3 debounce frames + 12 held frames
    base = fr;
    push(1, 12, T_PRESS,  base + 3);
    push(1, 12, T_REPEAT, base + 8);
    push(1, 12, T_REPEAT, base + 10);
    push(1, 12, T_REPEAT, base + 12);
    push(1, 12, T_REPEAT, base + 14);
    mask_b = 16'h1000;
    frames(15);
    chk("rpt_key_down", 32'(kd_b), 32'd1);
    push(1, 12, T_RELEASE, base + 18);
    mask_b = '0;
    frames(5);
    chk("rpt_sb_empty", 32'(sb_q.size()), 32'd0);
    chk("rpt_overflow", 32'(ovf_b), 32'd0);

    // single-frame debounce: press and release after one frame each
    base = fr;
    push(2, 6, T_PRESS, base + 1);
    mask_c = 16'h0040;
    frames(3);
    chk("deb1_key_down", 32'(kd_c), 32'd1);
    push(2, 6, T_RELEASE, base + 4);
    mask_c = '0;
    frames(2);
    chk("deb1_key_up", 32'(kd_c), 32'd0);
    chk("deb1_sb_empty", 32'(sb_q.size()), 32'd0);
    chk("deb1_overflow", 32'(ovf_c), 32'd0);

    // consumer stalled: press held, release dropped
    chk("ovf_pre", 32'(ovf_a), 32'd0);
    rdy_a = 1'b0;
    push(0, 2, T_PRESS, -1);
    mask_a = 16'h0004;
    frames(5);
    chk("stall_valid", 32'(v_a),    32'd1);
    chk("stall_code",  32'(code_a), 32'd2);
    chk("stall_type",  32'(type_a), 32'd0);
    chk("stall_ovf",   32'(ovf_a),  32'd0);
    mask_a = '0;
    frames(5);
    chk("drop_valid",    32'(v_a),    32'd1);
    chk("drop_code",     32'(code_a), 32'd2);
    chk("drop_type",     32'(type_a), 32'd0);
    chk("drop_overflow", 32'(ovf_a),  32'd1);
    chk("drop_key_down", 32'(kd_a),   32'd0);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("ovf_cleared", 32'(ovf_a), 32'd0);
    chk("ovf_clr_keeps_valid", 32'(v_a), 32'd1);
    @(posedge clk);
    #1 rdy_a = 1'b1;
    repeat (FRAME - 1) @(negedge clk);
    fr++;
    chk("drain_valid", 32'(v_a), 32'd0);
    chk("drain_sb_empty", 32'(sb_q.size()), 32'd0);

    // reset mid-HELD with an undelivered press in the buffer
    rdy_a = 1'b0;
    mask_a = 16'h0020;
    frames(5);
    chk("pend_valid",    32'(v_a),    32'd1);
    chk("pend_code",     32'(code_a), 32'd5);
    chk("pend_key_down", 32'(kd_a),   32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_col",      32'(col_a),  32'hE);
    chk("mid_rst_valid",    32'(v_a),    32'd0);
    chk("mid_rst_code",     32'(code_a), 32'd0);
    chk("mid_rst_type",     32'(type_a), 32'd0);
    chk("mid_rst_key_down", 32'(kd_a),   32'd0);
    chk("mid_rst_overflow", 32'(ovf_a),  32'd0);
    mask_a = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    fr = 0;
    rdy_a = 1'b1;
    frames(6);
    chk("post_rst_key_down", 32'(kd_a), 32'd0);
    chk("post_rst_valid",    32'(v_a),  32'd0);
    chk("final_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
